// File: rtl/panda_id_stage.sv
// Panda RV32I decode stage: register file, immediate generation, control decode,
// load-use hazard detection and the ID/EX pipeline register.

package panda_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_inc;
    } if_id_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_inc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        illegal;
    } id_ex_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

module panda_id_stage
    import panda_pkg::*;
#(
    parameter int          RegCount = 32,
    parameter logic [31:0] ResetPc  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  if_id_t      if_id_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_o,
    output id_ex_t      id_ex_o
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_field;

    assign instr    = if_id_i.instr;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign rd_field = instr[11:7];

    // ---------------- register file ----------------
    logic [31:0] rf_q [RegCount];
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    // NOTE: the register file must read as zero after reset, so it is built from
    // resettable flops; a RAM macro would need an explicit clearing sequence instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RegCount; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we_i && (wb_addr_i != 5'd0)) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

    // A nonzero read address matching wb_addr_i implies the write is not to x0.
    assign rs1_data = (rs1_addr == 5'd0)                     ? 32'd0     :
                      (wb_we_i && (wb_addr_i == rs1_addr))   ? wb_data_i :
                                                               rf_q[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0)                     ? 32'd0     :
                      (wb_we_i && (wb_addr_i == rs2_addr))   ? wb_data_i :
                                                               rf_q[rs2_addr];

    // ---------------- immediates ----------------
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // ---------------- control decode ----------------
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src_imm, alu_src_pc;
    logic        reg_we, mem_re, mem_we, branch, jump, jalr, illegal;
    logic        rs1_used, rs2_used;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        imm         = 32'd0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        jalr        = 1'b0;
        illegal     = 1'b0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;

        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    imm = imm_u; alu_op = ALU_PASS_B; alu_src_imm = 1'b1; reg_we = 1'b1;
                end
                OPC_AUIPC: begin
                    imm = imm_u; alu_src_imm = 1'b1; alu_src_pc = 1'b1; reg_we = 1'b1;
                end
                OPC_JAL: begin
                    imm = imm_j; alu_src_imm = 1'b1; alu_src_pc = 1'b1;
                    reg_we = 1'b1; jump = 1'b1;
                end
                OPC_JALR: begin
                    imm = imm_i; alu_src_imm = 1'b1; reg_we = 1'b1;
                    jump = 1'b1; jalr = 1'b1; rs1_used = 1'b1;
                end
                OPC_BRANCH: begin
                    imm = imm_b; alu_op = ALU_SUB; branch = 1'b1;
                    rs1_used = 1'b1; rs2_used = 1'b1;
                end
                OPC_LOAD: begin
                    imm = imm_i; alu_src_imm = 1'b1; reg_we = 1'b1; mem_re = 1'b1;
                    rs1_used = 1'b1;
                end
                OPC_STORE: begin
                    imm = imm_s; alu_src_imm = 1'b1; mem_we = 1'b1;
                    rs1_used = 1'b1; rs2_used = 1'b1;
                end
                OPC_OP_IMM: begin
                    imm = imm_i; alu_src_imm = 1'b1; reg_we = 1'b1; rs1_used = 1'b1;
                    alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
                    if ((funct3 == 3'b001) && (funct7 != 7'b0000000)) illegal = 1'b1;
                    if ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                        (funct7 != 7'b0100000)) illegal = 1'b1;
                end
                OPC_OP: begin
                    reg_we = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                    alu_op = alu_from_funct3(funct3, instr[30]);
                    if (!((funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) &&
                           ((funct3 == 3'b000) || (funct3 == 3'b101))))) illegal = 1'b1;
                end
                OPC_MISC_MEM, OPC_SYSTEM: begin
                end
                default: illegal = 1'b1;
            endcase
        end

        if (illegal) begin
            reg_we = 1'b0;
            mem_re = 1'b0;
            mem_we = 1'b0;
            branch = 1'b0;
            jump   = 1'b0;
            jalr   = 1'b0;
        end
    end

    // ---------------- hazard and ID/EX register ----------------
    id_ex_t id_ex_q;
    id_ex_t id_ex_d;

    assign stall_o = id_ex_q.valid && id_ex_q.mem_re && (id_ex_q.rd_addr != 5'd0) &&
                     ((rs1_used && (rs1_addr == id_ex_q.rd_addr)) ||
                      (rs2_used && (rs2_addr == id_ex_q.rd_addr)));

    always_comb begin
        id_ex_d             = '0;
        id_ex_d.valid       = 1'b1;
        id_ex_d.pc          = if_id_i.pc;
        id_ex_d.pc_inc      = if_id_i.pc_inc;
        id_ex_d.rs1_addr    = rs1_addr;
        id_ex_d.rs2_addr    = rs2_addr;
        id_ex_d.rd_addr     = reg_we ? rd_field : 5'd0;
        id_ex_d.rs1_data    = rs1_data;
        id_ex_d.rs2_data    = rs2_data;
        id_ex_d.imm         = imm;
        id_ex_d.alu_op      = alu_op;
        id_ex_d.funct3      = funct3;
        id_ex_d.alu_src_imm = alu_src_imm;
        id_ex_d.alu_src_pc  = alu_src_pc;
        id_ex_d.reg_we      = reg_we;
        id_ex_d.mem_re      = mem_re;
        id_ex_d.mem_we      = mem_we;
        id_ex_d.branch      = branch;
        id_ex_d.jump        = jump;
        id_ex_d.jalr        = jalr;
        id_ex_d.illegal     = illegal;

        // Flush wins over stall, but both produce the same bubble.
        if (flush_i || stall_o) begin
            id_ex_d.valid   = 1'b0;
            id_ex_d.rd_addr = 5'd0;
            id_ex_d.reg_we  = 1'b0;
            id_ex_d.mem_re  = 1'b0;
            id_ex_d.mem_we  = 1'b0;
            id_ex_d.branch  = 1'b0;
            id_ex_d.jump    = 1'b0;
            id_ex_d.jalr    = 1'b0;
            id_ex_d.illegal = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_ex_q        <= '0;
            id_ex_q.pc     <= ResetPc;
            id_ex_q.pc_inc <= ResetPc;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex_o = id_ex_q;

endmodule
